alu_req_scheduler: RTL and testbench

Shares one ALU_Core instance between two requesters through valid/ready handshakes. A round-robin arbiter selects one request, and the block registers its operands. It then holds them stable on the ALU_Core inputs for a fixed execute window, captures the 8-bit result and presents it with the winning requester's ID on a single result port with backpressure. It sits between the operand sources and the result consumer, and is the only driver of ALU_Core inputs.

---
 rtl/alu_sched_pkg.sv | 25 ++
 rtl/alu_core.sv | 43 ++++
 rtl/rr_arb2.sv | 39 +++
 rtl/alu_req_scheduler.sv | 117 +++++++++++
 tb/tb_alu_req_scheduler.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// ============================================================================
// Module      : alu_sched_pkg
// Description : Shared opcodes, FSM state type and ID width for the ALU request scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_sched_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_AVG = 2'b11;

   localparam int ID_W = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : ALU_Core
// Description : 4-bit combinational ALU; SUB is sign-magnitude, AVG carries the half bit in Y[7].
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ALU_Core
   import alu_sched_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [1:0] OP,
   output logic [7:0] Y
);

   logic [4:0] sum;
   logic [3:0] diff;

   assign sum = {1'b0, A} + {1'b0, B};

   always_comb begin
      Y    = 8'h00;
      diff = 4'h0;
      case (OP)
         OP_ADD: Y = {3'b000, sum};
         OP_SUB: begin
            if (A >= B) begin
               diff = A - B;
               Y    = {4'h0, diff};
            end else begin
               diff = B - A;
               Y    = {4'h8, diff};
            end
         end
         OP_MUL: Y = {4'h0, A} * {4'h0, B};
         OP_AVG: Y = {sum[0], 3'b000, sum[4:1]};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter; pointer moves to the loser on each advance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic ptr;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end

   assign grant_idx = grant[1];

   // Flips even for a lone requester so a late competitor wins the next contest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (advance) begin
         ptr <= ~grant_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_req_scheduler.sv
// ============================================================================
// Module      : alu_req_scheduler
// Description : Shares one ALU_Core between two valid/ready requesters with a backpressured result port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_req_scheduler
   import alu_sched_pkg::*;
#(
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic [1:0]       req1_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_y,
   output logic [ID_W-1:0]  res_id,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   state_t          state;
   logic [3:0]      exec_cnt;
   logic [3:0]      opa;
   logic [3:0]      opb;
   logic [1:0]      opc;
   logic [ID_W-1:0] id_q;
   logic [1:0]      grant;
   logic            grant_idx;
   logic            handshake;
   logic [7:0]      alu_y;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({req1_valid, req0_valid}),
      .advance   (handshake),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   ALU_Core u_alu (
      .A  (opa),
      .B  (opb),
      .OP (opc),
      .Y  (alu_y)
   );

   assign handshake  = (state == IDLE) && (grant != 2'b00);
   // READY is masked by reset so a held VALID cannot handshake while reset is asserted.
   assign req0_ready = rst_n & handshake & grant[0];
   assign req1_ready = rst_n & handshake & grant[1];
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         exec_cnt  <= 4'd0;
         opa       <= 4'd0;
         opb       <= 4'd0;
         opc       <= 2'b00;
         id_q      <= '0;
         res_valid <= 1'b0;
         res_y     <= 8'h00;
         res_id    <= '0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  opa      <= grant_idx ? req1_a  : req0_a;
                  opb      <= grant_idx ? req1_b  : req0_b;
                  opc      <= grant_idx ? req1_op : req0_op;
                  id_q     <= ID_W'(grant_idx);
                  exec_cnt <= EXEC_LOAD;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (exec_cnt == 4'd0) begin
                  res_y     <= alu_y;
                  res_id    <= id_q;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  exec_cnt <= exec_cnt - 4'd1;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
// ============================================================================
// Module      : tb_alu_req_scheduler
// Description : Self-checking bench for alu_req_scheduler against an arithmetic reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_req_scheduler;
   import alu_sched_pkg::*;

   localparam int E     = 1;
   localparam int E4    = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]       req0_a, req0_b, req1_a, req1_b;
   logic [1:0]       req0_op, req1_op;
   logic             res_valid, res_ready, busy;
   logic [7:0]       res_y;
   logic [ID_W-1:0]  res_id;
   logic [CNT_W-1:0] op_count;

   logic             req0_ready_4, req1_ready_4, res_valid_4, busy_4;
   logic             res_ready_4 = 1'b1;
   logic [7:0]       res_y_4;
   logic [ID_W-1:0]  res_id_4;
   logic [CNT_W-1:0] op_count_4;

   alu_req_scheduler #(.EXEC_CYCLES(E), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id),
      .busy(busy), .op_count(op_count)
   );

   alu_req_scheduler #(.EXEC_CYCLES(E4), .CNT_W(CNT_W)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .res_valid(res_valid_4), .res_ready(res_ready_4), .res_y(res_y_4), .res_id(res_id_4),
      .busy(busy_4), .op_count(op_count_4)
   );

   int vectors    = 0;
   int miscompares = 0;
   int exp_cnt    = 0;

   typedef struct {
      bit         id;
      logic [7:0] y;
      int         due;
   } exp_t;

   // Reference ALU written from the result encoding, not from gates.
   function automatic logic [7:0] model_y(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int sa, sb, d;
      sa = int'(a);
      sb = int'(b);
      case (op)
         2'b00: return 8'(sa + sb);
         2'b01: begin
            d = sa - sb;
            if (d < 0) return 8'h80 + 8'(-d);
            return 8'(d);
         end
         2'b10: return 8'(sa * sb);
         default: return (((sa + sb) % 2) != 0 ? 8'h80 : 8'h00) + 8'((sa + sb) / 2);
      endcase
   endfunction

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic apply_reset;
      @(negedge clk);
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      #1;
   endtask

   // Drives one request and returns what the DUT produced; the callers judge it.
   task automatic do_txn(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         output int wait_n, output int lat, output logic [7:0] y, output logic rid);
      @(negedge clk);
      res_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
      #1;
      wait_n = 0;
      while (!(id ? req1_ready : req0_ready) && wait_n < 20) begin
         step();
         wait_n++;
      end
      step();
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 40) begin
         step();
         lat++;
      end
      y   = res_y;
      rid = res_id;
      step();
      if (lat < 40) exp_cnt++;
   endtask

   task automatic test_reset;
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      vectors++;
      if ({req0_ready, req1_ready, res_valid, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0000", {req0_ready, req1_ready, res_valid, busy});
      end
      @(posedge clk);
      #1;
      vectors++;
      if (res_y !== 8'h00 || res_id !== 1'b0 || op_count !== 8'h00 || req0_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_regs: got y=%h id=%b cnt=%0d rdy0=%b expected 00/0/0/0", res_y, res_id, op_count, req0_ready);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      #1;
   endtask

   task automatic test_single;
      int w, l;
      logic [7:0] y;
      logic r;
      do_txn(1'b0, 4'd9, 4'd8, OP_ADD, w, l, y, r);
      vectors++;
      if (w !== 0 || l !== E + 1) begin
         miscompares++;
         $display("FAIL single_timing: got wait=%0d lat=%0d expected wait=0 lat=%0d", w, l, E + 1);
      end
      vectors++;
      if (y !== model_y(4'd9, 4'd8, OP_ADD) || r !== 1'b0) begin
         miscompares++;
         $display("FAIL single_result: got y=%h id=%b expected y=%h id=0", y, r, model_y(4'd9, 4'd8, OP_ADD));
      end
      vectors++;
      if (op_count !== CNT_W'(exp_cnt)) begin
         miscompares++;
         $display("FAIL single_count: got %0d expected %0d", op_count, exp_cnt);
      end
   endtask

   task automatic test_req1;
      int w, l;
      logic [7:0] y;
      logic r;
      do_txn(1'b1, 4'd3, 4'd5, OP_SUB, w, l, y, r);
      vectors++;
      if (y !== model_y(4'd3, 4'd5, OP_SUB) || r !== 1'b1) begin
         miscompares++;
         $display("FAIL req1_result: got y=%h id=%b expected y=%h id=1", y, r, model_y(4'd3, 4'd5, OP_SUB));
      end
      vectors++;
      if (op_count !== CNT_W'(exp_cnt)) begin
         miscompares++;
         $display("FAIL req1_count: got %0d expected %0d", op_count, exp_cnt);
      end
   endtask

   task automatic test_alternate;
      bit   exp_q[$];
      bit   nxt;
      int   got, cyc;
      logic [7:0] ey;
      apply_reset();
      nxt = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15; req0_op = OP_MUL;
      req1_valid = 1'b1; req1_a = 4'd7;  req1_b = 4'd4;  req1_op = OP_AVG;
      res_ready  = 1'b1;
      #1;
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 60) begin
         if (req0_ready || req1_ready) begin
            vectors++;
            if (req0_ready === req1_ready || req1_ready !== nxt) begin
               miscompares++;
               $display("FAIL alt_grant: got rdy0=%b rdy1=%b expected grant to %0d", req0_ready, req1_ready, nxt);
            end
            exp_q.push_back(nxt);
            nxt = ~nxt;
         end
         if (res_valid && exp_q.size() > 0) begin
            ey = exp_q[0] ? model_y(4'd7, 4'd4, OP_AVG) : model_y(4'd15, 4'd15, OP_MUL);
            vectors++;
            if (res_id !== exp_q[0] || res_y !== ey) begin
               miscompares++;
               $display("FAIL alt_result: got id=%b y=%h expected id=%b y=%h", res_id, res_y, exp_q[0], ey);
            end
            void'(exp_q.pop_front());
            got++;
            exp_cnt++;
         end
         step();
         cyc++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("FAIL alt_timeout: got %0d results expected 4", got);
      end
      // A fifth grant may have started on the last edge; let it drain.
      repeat (6) step();
      if (op_count == CNT_W'(exp_cnt + 1)) exp_cnt++;
   endtask

   task automatic test_stall;
      int n;
      logic [7:0] ey;
      @(negedge clk);
      res_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd2; req0_op = OP_MUL;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin step(); n++; end
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_op = OP_ADD;
      n = 0;
      while (!res_valid && n < 20) begin step(); n++; end
      ey = model_y(4'd6, 4'd2, OP_MUL);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if ({res_valid, res_y, res_id, req0_ready, req1_ready, busy} !== {1'b1, ey, 1'b0, 1'b0, 1'b0, 1'b1}
             || op_count !== CNT_W'(exp_cnt)) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b y=%h id=%b rdy=%b%b cnt=%0d expected v=1 y=%h id=0 rdy=00 cnt=%0d",
                     res_valid, res_y, res_id, req0_ready, req1_ready, op_count, ey, exp_cnt);
         end
         step();
      end
      res_ready = 1'b1;
      step();
      exp_cnt++;
      vectors++;
      if (op_count !== CNT_W'(exp_cnt) || res_valid !== 1'b0 || req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release: got cnt=%0d v=%b rdy1=%b expected cnt=%0d v=0 rdy1=1", op_count, res_valid, req1_ready, exp_cnt);
      end
      step();
      req1_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin step(); n++; end
      vectors++;
      if (res_y !== model_y(4'd1, 4'd1, OP_ADD) || res_id !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_next: got y=%h id=%b expected y=%h id=1", res_y, res_id, model_y(4'd1, 4'd1, OP_ADD));
      end
      step();
      exp_cnt++;
   endtask

   task automatic test_async_reset;
      int n, l;
      @(negedge clk);
      res_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5; req0_op = OP_ADD;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin step(); n++; end
      @(posedge clk);
      #3;
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      #1;
      vectors++;
      if ({res_valid, busy, req0_ready, req1_ready} !== 4'b0000 || res_y !== 8'h00 || op_count !== 8'h00) begin
         miscompares++;
         $display("FAIL areset_outputs: got v=%b busy=%b rdy=%b%b y=%h cnt=%0d expected all 0",
                  res_valid, busy, req0_ready, req1_ready, res_y, op_count);
      end
      @(negedge clk);
      #2;
      rst_n   = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_ghost: got v=%b busy=%b expected 0 0", res_valid, busy);
         end
      end
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd9; req0_op = OP_SUB;
      req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = OP_MUL;
      #1;
      vectors++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_ptr: got rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
      end
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      l = 0;
      while (!res_valid && l < 20) begin step(); l++; end
      vectors++;
      if (res_y !== model_y(4'd4, 4'd9, OP_SUB) || res_id !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_next: got y=%h id=%b expected y=%h id=0", res_y, res_id, model_y(4'd4, 4'd9, OP_SUB));
      end
      step();
      exp_cnt++;
   endtask

   task automatic test_random;
      bit         pend[2];
      logic [3:0] pa[2], pb[2];
      logic [1:0] po[2];
      bit         idle, last, g, rr;
      exp_t       q[$];
      exp_t       e;
      bit         exp_rv;
      apply_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      idle = 1'b1;
      last = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
               pend[k] = 1'b1;
               pa[k] = 4'($urandom);
               pb[k] = 4'($urandom);
               po[k] = 2'($urandom);
            end
         end
         req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
         req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
         rr = ($urandom_range(0, 3) != 0);
         res_ready = rr;
         #1;
         vectors++;
         if (busy !== !idle || op_count !== CNT_W'(exp_cnt)) begin
            miscompares++;
            $display("FAIL rnd_state cyc %0d: got busy=%b cnt=%0d expected busy=%b cnt=%0d", cyc, busy, op_count, !idle, CNT_W'(exp_cnt));
         end
         exp_rv = (q.size() > 0) && (cyc >= q[0].due);
         vectors++;
         if (res_valid !== exp_rv || (exp_rv && (res_y !== q[0].y || res_id !== q[0].id))) begin
            miscompares++;
            $display("FAIL rnd_result cyc %0d: got v=%b y=%h id=%b expected v=%b y=%h id=%b", cyc, res_valid, res_y, res_id,
                     exp_rv, exp_rv ? q[0].y : 8'h00, exp_rv ? q[0].id : 1'b0);
         end
         vectors++;
         if (idle && (pend[0] || pend[1])) begin
            g = (pend[0] && pend[1]) ? ~last : pend[1];
            if (req0_ready !== !g || req1_ready !== g) begin
               miscompares++;
               $display("FAIL rnd_grant cyc %0d: got rdy=%b%b expected grant %0d", cyc, req1_ready, req0_ready, g);
            end
            e.id  = g;
            e.y   = model_y(pa[g], pb[g], po[g]);
            e.due = cyc + E + 1;
            q.push_back(e);
            pend[g] = 1'b0;
            last = g;
            idle = 1'b0;
         end else if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_ready cyc %0d: got rdy=%b%b expected 00", cyc, req1_ready, req0_ready);
         end
         if (exp_rv && rr) begin
            void'(q.pop_front());
            exp_cnt++;
            idle = 1'b1;
         end
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
   endtask

   task automatic test_wrap;
      int w, l;
      logic [7:0] y;
      logic r;
      bit id;
      logic [3:0] a, b;
      logic [1:0] op;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         id = 1'($urandom);
         a  = 4'($urandom);
         b  = 4'($urandom);
         op = 2'($urandom);
         do_txn(id, a, b, op, w, l, y, r);
         vectors++;
         if (y !== model_y(a, b, op) || r !== id || l !== E + 1) begin
            miscompares++;
            $display("FAIL wrap_txn %0d: got y=%h id=%b lat=%0d expected y=%h id=%b lat=%0d", i, y, r, l, model_y(a, b, op), id, E + 1);
         end
         if (i == 254) begin
            vectors++;
            if (op_count !== 8'd255) begin
               miscompares++;
               $display("FAIL wrap_255: got %0d expected 255", op_count);
            end
         end
      end
      vectors++;
      if (op_count !== 8'd0) begin
         miscompares++;
         $display("FAIL wrap_zero: got %0d expected 0", op_count);
      end
   endtask

   task automatic test_latency4;
      int n, l;
      apply_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_op = OP_MUL;
      #1;
      n = 0;
      while (!req0_ready_4 && n < 20) begin step(); n++; end
      step();
      req0_valid = 1'b0;
      l = 1;
      while (!res_valid_4 && l < 40) begin step(); l++; end
      vectors++;
      if (n !== 0 || l !== E4 + 1) begin
         miscompares++;
         $display("FAIL lat4: got wait=%0d lat=%0d expected wait=0 lat=%0d", n, l, E4 + 1);
      end
      vectors++;
      if (res_y_4 !== model_y(4'd2, 4'd3, OP_MUL) || res_id_4 !== 1'b0) begin
         miscompares++;
         $display("FAIL lat4_result: got y=%h id=%b expected y=%h id=0", res_y_4, res_id_4, model_y(4'd2, 4'd3, OP_MUL));
      end
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_op = 2'b00;
      req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_op = 2'b00;
      res_ready  = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_single();
      test_req1();
      test_alternate();
      test_stall();
      test_async_reset();
      test_random();
      test_wrap();
      test_latency4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
